// File: rtl/fpu_pkg.sv
// Shared definitions for the float-to-integer conversion scheduler:
// rounding-mode encodings, the S1 payload layout and rm legality.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // Tag width carried in the S1 payload; the scheduler's TAG_W defaults to this.
    localparam int CVT_TAG_W = 5;

    typedef struct packed {
        logic [31:0]          src;
        logic [2:0]           rm;
        logic                 is_signed;
        logic [CVT_TAG_W-1:0] tag;
        logic                 lane;
        logic                 illegal;
    } s1_payload_t;

    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/fpu_flt2int.sv
// Combinational single-precision to 32-bit integer conversion with
// rounding and saturation (NaN saturates to the positive maximum).
module fpu_flt2int
    import fpu_pkg::*;
(
    input  logic [31:0] src,
    input  logic [2:0]  rm,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic               sgn;
    logic               is_nan;
    logic [7:0]         expo;
    logic [23:0]        sig;
    logic [63:0]        fixed;
    logic [31:0]        int_part;
    logic               guard;
    logic               sticky;
    logic               inc;
    logic [32:0]        mag;
    logic signed [31:0] neg_val;

    always_comb begin
        sgn    = src[31];
        expo   = src[30:23];
        is_nan = (expo == 8'hFF) && (src[22:0] != 23'd0);
        sig    = {expo != 8'd0, src[22:0]};

        // Integer part in [63:32], fraction in [31:0]; below 2^-9 only stickiness matters.
        fixed = 64'd0;
        if (expo >= 8'd118 && expo <= 8'd158)
            fixed = {40'd0, sig} << (expo - 8'd118);
        int_part = fixed[63:32];
        guard    = fixed[31];
        sticky   = (|fixed[30:0]) | ((expo < 8'd118) & (|src[30:0]));

        case (rm)
            RM_RNE:  inc = guard & (sticky | int_part[0]);
            RM_RDN:  inc = sgn & (guard | sticky);
            RM_RUP:  inc = ~sgn & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = 1'b0;
        endcase

        mag     = {1'b0, int_part} + {32'd0, inc};
        neg_val = -$signed(mag[31:0]);

        if (expo > 8'd158) begin
            if (is_signed)
                result = (sgn && !is_nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else
                result = (sgn && !is_nan) ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end else if (is_signed) begin
            if (sgn)
                result = (mag > 33'h0_8000_0000) ? 32'h8000_0000 : neg_val;
            else
                result = (mag > 33'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : mag[31:0];
        end else begin
            if (sgn)
                result = 32'h0000_0000;
            else
                result = mag[32] ? 32'hFFFF_FFFF : mag[31:0];
        end
    end

endmodule

// File: rtl/fpu_rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the granted lane
// only when a grant is actually consumed.
module fpu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_ptr;

    always_comb begin
        grant = 2'b00;
        if (req[rr_ptr])
            grant[rr_ptr] = 1'b1;
        else if (req[~rr_ptr])
            grant[~rr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (advance)
            rr_ptr <= ~grant[1];
    end

endmodule

// File: rtl/fpu_cvt_sched.sv
// Two-lane round-robin scheduler around the shared float-to-int converter:
// issue register S1, converter, result register S2, with backpressure and flush.
module fpu_cvt_sched
    import fpu_pkg::*;
#(
    parameter int TAG_W = CVT_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_op_signed,
    input  logic [1:0][2:0]       req_rm,
    input  logic [1:0][31:0]      req_src,
    input  logic [1:0][TAG_W-1:0] req_tag,
    input  logic [2:0]            frm,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_lane,
    output logic                  out_illegal,
    output logic                  busy
);

    logic                 s1_valid;
    logic                 s2_valid;
    s1_payload_t          s1;
    s1_payload_t          s1_next;
    logic [31:0]          cvt_data;
    logic [31:0]          s2_data;
    logic [CVT_TAG_W-1:0] s2_tag;
    logic                 s2_lane;
    logic                 s2_illegal;
    logic                 s2_free;
    logic                 s1_adv;
    logic                 can_accept;
    logic                 accept;
    logic                 sel;
    logic [1:0]           grant;
    logic [2:0]           eff_rm;

    assign s2_free    = ~s2_valid | out_ready;
    assign s1_adv     = s1_valid & s2_free;
    assign can_accept = (~s1_valid | s1_adv) & ~flush & ~rst;
    assign req_ready  = grant & {2{can_accept}};
    assign accept     = |(req_valid & req_ready);
    assign sel        = grant[1];

    fpu_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        eff_rm            = (req_rm[sel] == RM_DYN) ? frm : req_rm[sel];
        s1_next.src       = req_src[sel];
        s1_next.rm        = eff_rm;
        s1_next.is_signed = req_op_signed[sel];
        s1_next.tag       = CVT_TAG_W'(req_tag[sel]);
        s1_next.lane      = sel;
        s1_next.illegal   = rm_is_illegal(eff_rm);
    end

    // S1: issue register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (flush)
            s1_valid <= 1'b0;
        else if (accept)
            s1_valid <= 1'b1;
        else if (s1_adv)
            s1_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept)
            s1 <= s1_next;
    end

    fpu_flt2int u_cvt (
        .src       (s1.src),
        .rm        (s1.rm),
        .is_signed (s1.is_signed),
        .result    (cvt_data)
    );

    // S2: result register; data is reset too so outputs read zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_data    <= 32'd0;
            s2_tag     <= '0;
            s2_lane    <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s2_free)
                s2_valid <= s1_valid;
            if (s1_adv) begin
                s2_data    <= s1.illegal ? 32'd0 : cvt_data;
                s2_tag     <= s1.tag;
                s2_lane    <= s1.lane;
                s2_illegal <= s1.illegal;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_data    = s2_data;
    assign out_tag     = TAG_W'(s2_tag);
    assign out_lane    = s2_lane;
    assign out_illegal = s2_illegal;
    assign busy        = s1_valid | s2_valid;

endmodule

// File: doc/fpu_cvt_sched.md
Name: fpu_cvt_sched

Overview:
Two-requester scheduler and pipeline wrapper for the shared float-to-integer conversion datapath (fpu_flt2int) in the EX stage. It arbitrates round-robin between two issue lanes and resolves the dynamic rounding mode from the frm CSR. Accepted operations pass through a 2-stage pipeline: an issue register, then the converter, then a result register. Results return with the requester's tag and an id bit, under valid/ready backpressure and pipeline flush.

Parameters:
TAG_W, 5, width of the per-operation tag returned with the result

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  2  per-lane request valid
req_ready  out  2  per-lane accept; a transfer happens when req_valid[i] & req_ready[i]
req_op_signed  in  2  per-lane: 1 = signed result (FCVT.W.S), 0 = unsigned (FCVT.WU.S)
req_rm  in  2x3  per-lane instruction rm field; 3'b111 = dynamic
req_src  in  2x32  per-lane single-precision operand
req_tag  in  2xTAG_W  per-lane tag
frm  in  3  current CSR rounding mode
flush  in  1  kill all in-flight operations
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  32  integer result
out_tag  out  TAG_W  tag of result
out_lane  out  1  lane that issued the result
out_illegal  out  1  resolved rm was illegal (101, 110, or dynamic with frm in 101..111)
busy  out  1  S1 or S2 holds a valid op

Behaviour:
- Reset state:
  - s1_valid = 0, s2_valid = 0, rr_ptr = 0.
  - out_data, out_tag, out_lane and out_illegal are 0; out_valid = 0; req_ready = 0.
- Pipeline register S1 holds: src, resolved rm, signed, tag, lane, illegal.
- Pipeline register S2 holds: converted data, tag, lane, illegal.
- Control equations:
  - s2_free = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - can_accept = (~s1_valid | s1_adv) & ~flush.
- Arbitration:
  - grant goes to lane rr_ptr if it requests, otherwise to the other lane.
  - req_ready[i] = grant[i] & can_accept; at most one lane is ready per cycle.
  - req_ready depends combinationally on req_valid.
  - After an accepted transfer, rr_ptr <= ~granted lane. Without a transfer, rr_ptr holds.
- rm resolution (at accept):
  - eff = (req_rm == 3'b111) ? frm : req_rm.
  - illegal = eff in {101, 110, 111}.
  - Illegal ops still flow through the pipeline; S2 data is forced to 0 and out_illegal = 1.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+2 when there is no backpressure.
  - Throughput is 1 op/cycle.
- Backpressure:
  - While out_valid & ~out_ready, all out_* hold stable.
  - S1 holds if S2 cannot drain.
  - req_ready falls to 0 once S1 is full and blocked.
  - Simultaneous drain of S2 and advance of S1 in the same cycle is legal and is the normal case.
- flush:
  - Synchronous; s1_valid <= 0 and s2_valid <= 0 next edge.
  - req_ready = 0 during flush, so no op is accepted that cycle.
  - rr_ptr is unchanged.
  - Flush overrides out_ready, but an out_valid & out_ready handshake in the flush cycle still counts as delivered.
- Async reset asserted mid-operation: all valids clear immediately and in-flight ops are lost; no output handshake occurs.
- Conversion semantics (out-of-range saturation, negative-to-unsigned = 0) are those of fpu_flt2int; the scheduler does not alter them.

Decomposition:
- Shared package fpu_pkg:
  - rounding-mode constants RNE/RTZ/RDN/RUP/RMM/DYN (3'b111);
  - rm_is_illegal function;
  - struct for the S1 payload (src, rm, signed, tag, lane, illegal).
- Sub-module fpu_rr_arb2: 2-input round-robin arbiter with req, advance and grant, owning rr_ptr.
- fpu_flt2int is instantiated between S1 and S2.

Test Plan:
- Single op: lane 0, src 0x40490FDB, rm RNE, signed, tag 3, out_ready=1 → out_valid 2 cycles later, out_data 0x00000003, out_tag 3, out_lane 0.
- Dynamic rm: lane 1, rm 3'b111, frm RDN, src 0xBF000000, signed → 0xFFFFFFFF. Repeat with frm 3'b101 → out_illegal 1, out_data 0.
- Fairness: both lanes request every cycle for 6 cycles → accept order 0,1,0,1,0,1, results in the same order. src 0x40200000 with rm RUP → 3; with rm RNE → 2.
- Backpressure: out_ready low for 3 cycles during streaming → out_* stable, req_ready 0 after S1 fills, no op lost or duplicated after release.
- Saturation: src 0x4F800000 signed RTZ → 0x7FFFFFFF; src 0xC0200000 unsigned → 0x00000000.
- Flush and reset: flush with S1 and S2 full → out_valid 0 next cycle, busy 0, req_ready 0 in the flush cycle. Async rst mid-stream → all outputs 0 immediately.
